// File: rtl/add_serial.sv
// add_serial -- bit-serial unsigned adder.
//
// Purpose:
//   Adds two WIDTH-bit operands LSB-first, one bit per clock, through a
//   single full-adder cell and a carry flop.  It is the sequential,
//   minimal-logic counterpart of the combinational arithmetic blocks and
//   undoes the subtractor: feeding ((x - y) mod 2^WIDTH, y) returns x.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset; aborts any operation
//   start  in   1      request pulse, only honoured while idle
//   a      in   WIDTH  first operand, captured on an accepted start
//   b      in   WIDTH  second operand, captured on an accepted start
//   busy   out  1      high while bits are being added
//   done   out  1      one-cycle pulse, sum/cout just updated
//   sum    out  WIDTH  (a + b) mod 2^WIDTH, held until the next completion
//   cout   out  1      carry out of the top bit, held with sum
//
// Timing: start sampled at edge k, bits processed at edges k+1 .. k+WIDTH,
// done high in the cycle after edge k+WIDTH, back in idle one edge later.

module add_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry of a full adder is the majority of its three inputs.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic             accept_s;
    logic             last_bit_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;

    logic             sum_bit_s;
    logic             carry_nxt_s;
    logic [WIDTH-1:0] res_nxt_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    // Next-state decode and control strobes for the IDLE/RUN/DONE sequence.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_bit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = ST_DONE;
                    last_bit_s   = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // The single full-adder cell; the new bit enters the result from the top
    // so that after WIDTH shifts bit 0 has arrived at position 0.
    always_comb begin
        sum_bit_s   = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
        carry_nxt_s = maj3(a_sh_r[0], b_sh_r[0], carry_r);
        res_nxt_s   = {sum_bit_s, res_r[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand shift registers, carry flop, bit counter and partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
        end else if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_r   <= res_nxt_s;
            cnt_r   <= cnt_r + CW'(1);
            carry_r <= carry_nxt_s;
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            res_r   <= res_r;
            cnt_r   <= cnt_r;
            carry_r <= carry_r;
        end
    end

    // Registered handshake; derived from the next state so busy and done
    // are mutually exclusive and glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_RUN);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    // Result outputs only change on the final bit, so partial sums never
    // become visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else if (last_bit_s) begin
            sum_r  <= res_nxt_s;
            cout_r <= carry_nxt_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial -- scoreboard bench for add_serial (WIDTH = 8).
// The driver pushes the expected {sum, cout, completion cycle} for every
// start the design must accept; a monitor sampling 1 time unit after each
// rising edge checks busy, done, and the held sum/cout against it.

module tb_add_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    add_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: everything expected is derived from the scoreboard head.
    initial begin
        logic [W-1:0] held_s;
        logic         held_c;
        logic         eb;
        logic         ed;
        held_s = '0;
        held_c = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_sum",  32'(sum),  32'd0);
                chk("rst_cout", 32'(cout), 32'd0);
                sb.delete();
                held_s = '0;
                held_c = 1'b0;
            end else begin
                eb = (sb.size() > 0) && (cyc >= sb[0].due - W) && (cyc < sb[0].due);
                ed = (sb.size() > 0) && (cyc == sb[0].due);
                chk("busy", 32'(busy), 32'(eb));
                chk("done", 32'(done), 32'(ed));
                if (ed) begin
                    held_s = sb[0].s;
                    held_c = sb[0].c;
                    void'(sb.pop_front());
                end
                chk("sum",  32'(sum),  32'(held_s));
                chk("cout", 32'(cout), 32'(held_c));
            end
        end
    end

    // Wait (bounded) for idle, issue one start, then scramble the operand
    // inputs so only the latched copies can produce the right answer.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] es, input logic ec);
        int waitc;
        waitc = 0;
        while ((busy || done) && waitc < 4 * W) begin
            @(negedge clk);
            waitc++;
        end
        if (busy || done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy=%0b done=%0b expected idle", busy, done);
        end else begin
            a     = xa;
            b     = xb;
            start = 1'b1;
            sb.push_back('{s: es, c: ec, due: cyc + 1 + W});
            @(negedge clk);
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
        end
    endtask

    task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int t;
        t = int'(xa) + int'(xb);
        run_op(xa, xb, W'(t % 256), (t >= 256));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic add and hold while idle.
        run_op(8'd5, 8'd3, 8'd8, 1'b0);
        repeat (6) @(negedge clk);

        // Wrap-around and zero.
        run_op(8'd255, 8'd1,   8'd0,  1'b1);
        run_op(8'd200, 8'd100, 8'd44, 1'b1);
        run_op(8'd0,   8'd0,   8'd0,  1'b0);

        // Start while busy must be ignored.
        run_op(8'd10, 8'd20, 8'd30, 1'b0);
        repeat (3) @(negedge clk);
        a     = 8'd99;
        b     = 8'd99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset in the middle of an operation, then a fresh add.
        run_op(8'd100, 8'd27, 8'd127, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd1, 8'd1, 8'd2, 1'b0);

        // Operand hold with scrambled inputs during RUN.
        run_op(8'h0F, 8'hF0, 8'hFF, 1'b0);

        // Random operands against plain integer addition.
        for (int i = 0; i < 60; i++) begin
            run_add(W'($urandom), W'($urandom));
        end

        // Inverse of the subtractor: (x - y) + y == x, carry iff y > x.
        for (int x = 0; x <= 126; x++) begin
            for (int y = 0; y <= 126; y += 3) begin
                run_op(W'(x - y), W'(y), W'(x), (y > x));
            end
        end

        repeat (3 * W) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add_serial.md
Name: add_serial

Overview:
- Multi-cycle, bit-serial adder. It is the inverse of the arithmetic subtractor block: for any x, y, feeding (x-y mod 2^WIDTH, y) reproduces x.
- Operands are captured on a start pulse and added LSB-first, one bit per clock, through a single full-adder cell and a carry flop.
- It sits beside the combinational arithmetic blocks as the area-minimal sequential counterpart, with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  first operand; captured on an accepted start.
- b  input  WIDTH  second operand; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  (a+b) mod 2^WIDTH; held until the next completion.
- cout  output  1  carry out of bit WIDTH-1; held with sum.

Behaviour:
- Reset (rst high at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry=0, shift registers=0. Reset overrides every other input and aborts any operation in progress. No partial result ever reaches sum/cout.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch a and b into internal shift registers, clear carry and counter, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), one bit per edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by 1; shift s into the MSB of the result shift register; counter increments.
  - On the edge processing bit WIDTH-1 (edge k+WIDTH): copy the completed result register to sum, copy the final carry to cout, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Latency: done is high in the cycle after edge k+WIDTH; for WIDTH=8, that is 8 edges after the start-sampling edge. Back-to-back throughput: one result per WIDTH+2 cycles.
- start while in RUN or DONE: ignored, with no queuing. The operation in flight is unaffected.
- a and b may change freely after the accepted start edge; only the latched copies are used.
- sum and cout change only at completion; between completions they hold the last result, or 0 after reset.
- Width rule: the result is truncated to WIDTH bits; the overflow bit appears only on cout. Operands are unsigned; 2's-complement callers ignore cout.
- busy and done are never high together. done is registered, not decoded from a combinational start.

Test Plan:
1. Reset, then start with a=5, b=3 → busy high for 8 cycles; done pulses once on the 8th edge after the start edge; sum=8, cout=0; sum stays 8 while idle.
2. Wrap-around: a=255, b=1 → sum=0, cout=1. Then a=200, b=100 → sum=44, cout=1. Then a=0, b=0 → sum=0, cout=0.
3. Start ignored while busy: start a=10, b=20; 3 cycles later pulse start with a=99, b=99 → a single done, sum=30, cout=0; no second done follows.
4. Reset mid-operation: start a=100, b=27; assert rst on the 4th RUN cycle → next cycle busy=0, done=0, sum=0, cout=0. A fresh start a=1, b=1 then yields sum=2.
5. Inverse check against the subtractor: for all x, y in 0..126 (same sweep as the subtractor bench), drive a=(x-y) mod 256, b=y → sum==x on every done. cout=1 exactly when y>x and y!=0. Compare with a scoreboard; zero mismatches required.
6. Operand hold: change a and b every cycle during RUN after an accepted start of a=0x0F, b=0xF0 → sum=0xFF, cout=0.
